spi_reg_bank: RTL and testbench

Parametrised SPI slave (mode 0) with an addressable register bank and a transaction counter. It replaces the fixed 8-bit SPI-to-LED path in the icestick top level. SPI inputs are synchronised into the `clk` domain, and a host can burst-read or burst-write `NREG` registers of `WIDTH` bits. Register 0 drives the board LEDs.

---
 rtl/spi_reg_bank_if.sv | 10 +
 rtl/spi_reg_bank.sv | 134 +++++++++++++
 tb/tb_spi_reg_bank.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_if.sv
// SPI mode-0 pin bundle between a host (master) and the register bank (slave).
interface spi_reg_bank_if;
    logic SCLK;
    logic MOSI;
    logic CE0;
    logic MISO;

    modport master (output SCLK, output MOSI, output CE0, input MISO);
    modport slave  (input SCLK, input MOSI, input CE0, output MISO);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave with a burst-addressable register bank and a completed-frame counter.
// SPI pins are synchronised into clk; register 0 low nibble drives the LEDs.
module spi_reg_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NREG        = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_reg_bank_if.slave  spi,
    output logic [3:0]     led
);

    localparam int unsigned AW = WIDTH - 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ce0_sync_q;
    logic                   sclk_prev_q, ce0_prev_q;

    state_e                 state_q;
    logic [CW-1:0]          bitcnt_q;
    logic [AW-1:0]          rx_q;
    logic                   wr_q;
    logic [AW-1:0]          addr_q;
    logic [WIDTH-1:0]       tx_q;
    logic [WIDTH-1:0]       regs_q [NREG];
    logic [WIDTH-1:0]       fc_q;

    logic                   sclk_s, mosi_s, ce0_s;
    logic                   sclk_rise, sclk_fall, ce0_rise, ce0_fall;
    logic                   last_bit;
    logic [WIDTH-1:0]       word_c;
    logic [WIDTH-1:0]       rdata_c;

    // Synchronisers plus one edge-detect flop per pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ce0_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ce0_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
            ce0_sync_q  <= {ce0_sync_q[SYNC_STAGES-2:0],  spi.CE0};
            sclk_prev_q <= sclk_s;
            ce0_prev_q  <= ce0_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ce0_s     = ce0_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ce0_rise  = ce0_s & ~ce0_prev_q;
    assign ce0_fall  = ~ce0_s & ce0_prev_q;

    assign last_bit  = (bitcnt_q == CW'(WIDTH - 1));
    assign word_c    = {rx_q, mosi_s};

    // Addresses beyond the bank read back the frame counter
    always_comb begin
        rdata_c = fc_q;
        for (int i = 0; i < int'(NREG); i++) begin
            if (addr_q == AW'(i)) rdata_c = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            rx_q     <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            tx_q     <= '0;
            fc_q     <= '0;
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ce0_fall) begin
                        state_q  <= CMD;
                        bitcnt_q <= '0;
                        tx_q     <= '0;
                    end
                end
                CMD, DATA: begin
                    // CE0 rise wins over any coincident SCLK edge; partial words are dropped
                    if (ce0_rise) begin
                        state_q <= IDLE;
                        if (state_q == DATA) fc_q <= fc_q + WIDTH'(1);
                    end else if (sclk_rise) begin
                        rx_q     <= word_c[AW-1:0];
                        bitcnt_q <= last_bit ? '0 : bitcnt_q + CW'(1);
                        if (last_bit) begin
                            if (state_q == CMD) begin
                                wr_q    <= word_c[WIDTH-1];
                                addr_q  <= word_c[AW-1:0];
                                state_q <= DATA;
                            end else begin
                                if (wr_q) begin
                                    for (int i = 0; i < int'(NREG); i++) begin
                                        if (addr_q == AW'(i)) regs_q[i] <= word_c;
                                    end
                                end
                                addr_q <= addr_q + AW'(1);
                            end
                        end
                    end else if (sclk_fall) begin
                        if (state_q == DATA && bitcnt_q == '0 && !wr_q) begin
                            tx_q <= rdata_c;
                        end else begin
                            tx_q <= {tx_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi.MISO = tx_q[WIDTH-1];
    assign led      = regs_q[0][3:0];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: SPI host model driving mode-0 frames at clk = 12 x SCLK.
module tb_spi_reg_bank;

    localparam int HALF = 6;

    typedef logic [7:0] byte_arr_t [4];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] led;

    int checks = 0;
    int errors = 0;
    int fc_exp = 0;

    spi_reg_bank_if spi_bus ();

    spi_reg_bank #(
        .WIDTH       (8),
        .NREG        (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi_bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit: MOSI set while SCLK low, MISO sampled just before the rise
    task automatic spi_bit(input logic b, output logic m);
        spi_bus.MOSI = b;
        clk_wait(HALF);
        m = spi_bus.MISO;
        spi_bus.SCLK = 1'b1;
        clk_wait(HALF);
        spi_bus.SCLK = 1'b0;
    endtask

    task automatic spi_word(input logic [7:0] d, input int nbits, output logic [7:0] r);
        logic m;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(d[7-i], m);
            r = {r[6:0], m};
        end
    endtask

    task automatic frame_start();
        spi_bus.CE0 = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic frame_stop();
        clk_wait(HALF);
        spi_bus.CE0  = 1'b1;
        spi_bus.MOSI = 1'b0;
        clk_wait(2 * HALF);
    endtask

    task automatic wr_frame(input logic [7:0] cmd, input byte_arr_t d, input int n);
        logic [7:0] r;
        frame_start();
        spi_word(cmd, 8, r);
        for (int i = 0; i < n; i++) spi_word(d[i], 8, r);
        frame_stop();
        fc_exp++;
    endtask

    task automatic rd_frame(input logic [7:0] cmd, input int n,
                            output byte_arr_t d, output logic [7:0] cmd_miso);
        logic [7:0] r;
        d = '{8'h00, 8'h00, 8'h00, 8'h00};
        frame_start();
        spi_word(cmd, 8, cmd_miso);
        for (int i = 0; i < n; i++) begin
            spi_word(8'h00, 8, r);
            d[i] = r;
        end
        frame_stop();
        fc_exp++;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        spi_bus.CE0  = 1'b1;
        spi_bus.SCLK = 1'b0;
        spi_bus.MOSI = 1'b0;
        clk_wait(5);
        rst_n = 1'b1;
        clk_wait(5);
        fc_exp = 0;
    endtask

    task automatic test_reset();
        byte_arr_t  d;
        logic [7:0] cm;
        do_reset();
        checks++;
        if (spi_bus.MISO !== 1'b0) begin
            errors++; $display("FAIL reset_miso: got %b expected 0", spi_bus.MISO);
        end
        checks++;
        if (led !== 4'h0) begin
            errors++; $display("FAIL reset_led: got %h expected 0", led);
        end
        rd_frame(8'h00, 4, d, cm);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (d[i] !== 8'h00) begin
                errors++; $display("FAIL reset_reg%0d: got %02h expected 00", i, d[i]);
            end
        end
        checks++;
        if (cm !== 8'h00) begin
            errors++; $display("FAIL reset_cmd_miso: got %02h expected 00", cm);
        end
        rd_frame(8'h04, 1, d, cm);
        checks++;
        if (d[0] !== 8'h01) begin
            errors++; $display("FAIL reset_fc: got %02h expected 01", d[0]);
        end
    endtask

    task automatic test_single_write();
        byte_arr_t  d;
        byte_arr_t  wd;
        logic [7:0] cm;
        logic [7:0] exp;
        wd = '{8'hA5, 8'h00, 8'h00, 8'h00};
        wr_frame(8'h81, wd, 1);
        checks++;
        if (led !== 4'h0) begin
            errors++; $display("FAIL single_led: got %h expected 0", led);
        end
        rd_frame(8'h01, 1, d, cm);
        checks++;
        if (d[0] !== 8'hA5) begin
            errors++; $display("FAIL single_reg1: got %02h expected a5", d[0]);
        end
        exp = 8'(fc_exp);
        rd_frame(8'h04, 1, d, cm);
        checks++;
        if (d[0] !== exp) begin
            errors++; $display("FAIL single_fc: got %02h expected %02h", d[0], exp);
        end
    endtask

    task automatic test_burst_write();
        byte_arr_t  d;
        byte_arr_t  wd;
        logic [7:0] cm;
        wd = '{8'h0F, 8'h33, 8'h44, 8'h00};
        wr_frame(8'h80, wd, 3);
        checks++;
        if (led !== 4'hF) begin
            errors++; $display("FAIL burst_led: got %h expected f", led);
        end
        rd_frame(8'h01, 2, d, cm);
        checks++;
        if (d[0] !== 8'h33) begin
            errors++; $display("FAIL burst_reg1: got %02h expected 33", d[0]);
        end
        checks++;
        if (d[1] !== 8'h44) begin
            errors++; $display("FAIL burst_reg2: got %02h expected 44", d[1]);
        end
        checks++;
        if (cm !== 8'h00) begin
            errors++; $display("FAIL burst_cmd_miso: got %02h expected 00", cm);
        end
    endtask

    task automatic test_out_of_range();
        byte_arr_t  d;
        byte_arr_t  wd;
        logic [7:0] cm;
        logic [7:0] exp;
        wd = '{8'h11, 8'h22, 8'h00, 8'h00};
        wr_frame(8'h83, wd, 2);
        exp = 8'(fc_exp);
        rd_frame(8'h03, 2, d, cm);
        checks++;
        if (d[0] !== 8'h11) begin
            errors++; $display("FAIL oor_reg3: got %02h expected 11", d[0]);
        end
        checks++;
        if (d[1] !== exp) begin
            errors++; $display("FAIL oor_addr4: got %02h expected %02h", d[1], exp);
        end
    endtask

    task automatic test_read_wrap();
        byte_arr_t  d;
        byte_arr_t  wd;
        logic [7:0] cm;
        do_reset();
        wd = '{8'h0F, 8'h00, 8'h00, 8'h00};
        wr_frame(8'h80, wd, 1);
        wd = '{8'h33, 8'h00, 8'h00, 8'h00};
        wr_frame(8'h81, wd, 1);
        wd = '{8'h44, 8'h00, 8'h00, 8'h00};
        wr_frame(8'h82, wd, 1);
        rd_frame(8'h7F, 2, d, cm);
        checks++;
        if (d[0] !== 8'h03) begin
            errors++; $display("FAIL wrap_fc: got %02h expected 03", d[0]);
        end
        checks++;
        if (d[1] !== 8'h0F) begin
            errors++; $display("FAIL wrap_reg0: got %02h expected 0f", d[1]);
        end
        checks++;
        if (led !== 4'hF) begin
            errors++; $display("FAIL wrap_led: got %h expected f", led);
        end
    endtask

    task automatic test_abort();
        byte_arr_t  d;
        logic [7:0] cm;
        logic [7:0] r;
        logic [7:0] exp;
        frame_start();
        spi_word(8'h82, 8, r);
        spi_word(8'hFF, 5, r);
        frame_stop();
        fc_exp++;
        rd_frame(8'h02, 1, d, cm);
        checks++;
        if (d[0] !== 8'h44) begin
            errors++; $display("FAIL abort_reg2: got %02h expected 44", d[0]);
        end
        frame_start();
        spi_word(8'hFF, 3, r);
        frame_stop();
        exp = 8'(fc_exp);
        rd_frame(8'h04, 1, d, cm);
        checks++;
        if (d[0] !== exp) begin
            errors++; $display("FAIL abort_fc: got %02h expected %02h", d[0], exp);
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_arr_t  d;
        byte_arr_t  wd;
        logic [7:0] cm;
        logic [7:0] r;
        frame_start();
        spi_word(8'h83, 8, r);
        spi_word(8'h55, 4, r);
        rst_n = 1'b0;
        clk_wait(3);
        rst_n = 1'b1;
        fc_exp = 0;
        clk_wait(2);
        checks++;
        if (spi_bus.MISO !== 1'b0) begin
            errors++; $display("FAIL midrst_miso: got %b expected 0", spi_bus.MISO);
        end
        spi_word(8'h50, 4, r);
        checks++;
        if (r !== 8'h00) begin
            errors++; $display("FAIL midrst_tail_miso: got %02h expected 00", r);
        end
        frame_stop();
        rd_frame(8'h04, 1, d, cm);
        checks++;
        if (d[0] !== 8'h00) begin
            errors++; $display("FAIL midrst_fc: got %02h expected 00", d[0]);
        end
        rd_frame(8'h03, 1, d, cm);
        checks++;
        if (d[0] !== 8'h00) begin
            errors++; $display("FAIL midrst_reg3: got %02h expected 00", d[0]);
        end
        wd = '{8'h55, 8'h00, 8'h00, 8'h00};
        wr_frame(8'h83, wd, 1);
        rd_frame(8'h03, 1, d, cm);
        checks++;
        if (d[0] !== 8'h55) begin
            errors++; $display("FAIL midrst_rewrite: got %02h expected 55", d[0]);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        spi_bus.CE0  = 1'b1;
        spi_bus.SCLK = 1'b0;
        spi_bus.MOSI = 1'b0;
        test_reset();
        test_single_write();
        test_burst_write();
        test_out_of_range();
        test_read_wrap();
        test_abort();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
